// File: rtl/fifo.sv
// fifo: show-ahead single-clock FIFO; ports clk/reset, push/din in, pop/dout out, empty/full status
module fifo #(
  parameter int DEPTH      = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pop_ok, push_ok;
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == CW'(DEPTH);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rd_d    = pop_ok ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d    = push_ok ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    dout    = empty ? '0 : mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_q] <= din;
  end
endmodule

// File: tb/tb_fifo.sv
module tb_fifo;
  localparam int DEPTH = 5;
  localparam int DW    = 32;
  logic          clk = 0;
  logic          reset = 1;
  logic          push = 0;
  logic          pop = 0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          empty, full;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];

  fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(din), .dout(dout), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
    bit pop_ok, push_ok;
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    pop_ok  = q && sb.size() > 0;
    push_ok = p && (sb.size() < DEPTH || pop_ok);
    if (pop_ok) void'(sb.pop_front());
    if (push_ok) sb.push_back(d);
    #1;
    push = 0;
    pop  = 0;
    din  = '0;
  endtask

  task automatic test_reset;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    sb.delete();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_before[%0d]: got %b want 0", i, full); end
      step(1, 0, DW'(i));
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
      checks++; if (dout !== 32'd1) begin errors++; $display("FAIL fill_dout[%0d]: got %0d want 1", i, dout); end
      checks++; if (full !== (i == 5)) begin errors++; $display("FAIL fill_full_after[%0d]: got %b want %b", i, full, i == 5); end
    end
  endtask

  task automatic test_full_pushpop;
    step(1, 1, 32'd6);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_pushpop_full: got %b want 1", full); end
    checks++; if (dout !== 32'd2) begin errors++; $display("FAIL full_pushpop_dout: got %0d want 2", dout); end
  endtask

  task automatic test_drain;
    logic [DW-1:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp = sb.pop_front();
      sb.push_front(exp);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL drain_empty[%0d]: got %b want 0", i, empty); end
      checks++; if (dout !== exp || exp !== DW'(i + 2)) begin errors++; $display("FAIL drain_dout[%0d]: got %0d want %0d", i, dout, i + 2); end
      step(0, 1, '0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_empty_pop;
    step(0, 1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_pop_empty: got %b want 1", empty); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL empty_pop_dout: got %0d want 0", dout); end
    step(1, 0, 32'd7);
    checks++; if (dout !== 32'd7) begin errors++; $display("FAIL empty_pop_push7: got %0d want 7", dout); end
    step(0, 1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_pop_clear: got %b want 1", empty); end
  endtask

  task automatic test_full_push;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(10 + i));
    step(1, 0, 32'd99);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_push_full: got %b want 1", full); end
    checks++; if (dout !== 32'd10) begin errors++; $display("FAIL full_push_dout: got %0d want 10", dout); end
    for (int i = 0; i < DEPTH; i++) begin
      exp = sb[0];
      checks++; if (dout !== exp || exp !== DW'(10 + i)) begin errors++; $display("FAIL full_push_order[%0d]: got %0d want %0d", i, dout, 10 + i); end
      step(0, 1, '0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_push_drained: got %b want 1", empty); end
  endtask

  task automatic test_pushpop_empty_wrap;
    logic [DW-1:0] exp;
    step(1, 1, 32'd20);
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL pp_empty_flags: got empty=%b full=%b want 0 0", empty, full); end
    checks++; if (dout !== 32'd20) begin errors++; $display("FAIL pp_empty_dout: got %0d want 20", dout); end
    step(0, 1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty_count1: got empty=%b want 1", empty); end
    for (int i = 0; i < 24; i++) begin
      step(i % 4 != 3, (i % 3 == 2) || (i >= 16), DW'(100 + i));
      exp = (sb.size() > 0) ? sb[0] : '0;
      checks++;
      if (dout !== exp || empty !== (sb.size() == 0) || full !== (sb.size() == DEPTH)) begin
        errors++;
        $display("FAIL wrap[%0d]: got dout=%0d empty=%b full=%b want dout=%0d empty=%b full=%b",
                 i, dout, empty, full, exp, sb.size() == 0, sb.size() == DEPTH);
      end
    end
  endtask

  task automatic test_reset_mid;
    while (sb.size() > 0) step(0, 1, '0);
    for (int i = 0; i < 3; i++) step(1, 0, DW'(50 + i));
    checks++; if (dout !== 32'd50) begin errors++; $display("FAIL mid_pre_dout: got %0d want 50", dout); end
    reset = 1;
    push  = 1;
    pop   = 1;
    din   = 32'd77;
    @(posedge clk);
    #1;
    reset = 0;
    push  = 0;
    pop   = 0;
    sb.delete();
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got empty=%b full=%b want 1 0", empty, full); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL mid_reset_dout: got %0d want 0", dout); end
    step(1, 0, 32'd42);
    checks++; if (dout !== 32'd42) begin errors++; $display("FAIL mid_reset_push: got %0d want 42", dout); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_full_pushpop;
    test_drain;
    test_empty_pop;
    test_full_push;
    test_pushpop_empty_wrap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
Synchronous single-clock FIFO buffer with first-word-fall-through (show-ahead) output. Used as a per-port flit/packet queue in the router datapath.
Depth and data width are parameterised, including non-power-of-two depths. Status flags `empty` and `full` drive upstream/downstream flow control.

Parameters:
DEPTH, 5, number of storage entries (>= 2; any integer, not restricted to powers of two)
DATA_WIDTH, 32, bits per entry

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  write request; din captured at rising edge when accepted
pop  input  1  read request; head entry removed at rising edge when accepted
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  current head entry (show-ahead, combinational from storage)
empty  output  1  high when occupancy == 0
full  output  1  high when occupancy == DEPTH

Behaviour:
- State: storage array [DEPTH] x DATA_WIDTH, read pointer, write pointer, occupancy count (width clog2(DEPTH+1)).
- Reset (synchronous, active-high): pointers = 0, count = 0. Storage contents are not cleared. Resulting outputs: empty=1, full=0, dout=0.
- Flags are combinational decodes of count:
  - empty = (count == 0)
  - full = (count == DEPTH)
- dout = storage[read pointer] when not empty; 0 when empty.
- Show-ahead read: the oldest entry is visible on dout with no pop required. Pop consumes it; the next entry appears on dout in the same cycle the pointer advances (zero-cycle read latency).
- Write latency: data pushed at edge N is visible on dout after edge N if the FIFO was empty.
- Accept rules, evaluated each rising edge when reset is low:
  - pop_ok = pop && !empty
  - push_ok = push && (!full || pop_ok)
  - Push while full with no pop is dropped, with no state change.
  - Pop while empty is ignored, with no state change.
  - Push+pop while empty: push accepted, pop ignored, count becomes 1.
  - Push+pop while full: both accepted, count stays DEPTH, full stays 1, dout advances to the next entry.
  - Push+pop otherwise: both accepted, count unchanged.
- Pointer wrap: each pointer increments modulo DEPTH, so DEPTH-1 wraps to 0 (explicit compare, not bit overflow).
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Reset asserted mid-operation flushes all entries at the next edge, regardless of push/pop.
- No overflow/underflow error outputs; illegal requests are silently ignored.

Decomposition:
- No shared package required. DEPTH and DATA_WIDTH are module parameters; pointer and count widths are derived locally via $clog2.
- Single flat module; no sub-modules.

Test Plan:
- Reset for one cycle, then release -> empty=1, full=0.
- Push 1,2,3,4,5 on consecutive cycles -> full=0 before each edge, empty=0 after the first edge, full=1 after the fifth, dout=1 throughout.
- At full, push=1 and pop=1 with din=6 for one cycle -> full stays 1, dout=2.
- Pop five times -> dout reads 2,3,4,5,6 in order, empty=0 before each pop, empty=1 after the last.
- Boundary checks:
  - pop while empty -> empty stays 1, no pointer movement; a following push of 7 gives dout=7.
  - push while full with pop=0 -> contents unchanged, dout unchanged.
- Push+pop while empty, then wrap-around (more than DEPTH total pushes/pops interleaved) and reset asserted with 3 entries held -> count 1 after push+pop on empty; FIFO order preserved across wrap; after reset, empty=1 and full=0.
